// File: rtl/fb_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg -- shared definitions for the framebuffer arbiter.
//
// Holds the default framebuffer geometry, the frame size in words, the VGA
// line on which a buffer swap may take effect, the swap FSM state encoding,
// the write-queue entry layout and the pixel address helper.
// ---------------------------------------------------------------------------
package fb_pkg;

    localparam int FB_W_DEFAULT = 320;
    localparam int FB_H_DEFAULT = 240;
    localparam int FRAME_WORDS  = FB_W_DEFAULT * FB_H_DEFAULT;  // 76800

    // First line of vertical blanking in which the swap may be committed.
    localparam logic [9:0] VBLANK_LINE = 10'd515;

    localparam int ADDR_W = 18;

    typedef enum logic [1:0] {
        SWAP_IDLE = 2'd0,
        SWAP_PEND = 2'd1,
        SWAP_ACK  = 2'd2
    } swap_state_t;

    // One queued pixel write. The bank is not stored: the back bank cannot
    // change while entries are queued, because a swap only commits with the
    // queue empty.
    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [7:0] rgb;
    } wr_entry_t;

    // Linear RAM address of pixel (x, y) in the given bank.
    function automatic logic [ADDR_W-1:0] pixel_addr(
        input logic       bank,
        input logic [8:0] x,
        input logic [7:0] y,
        input int         width,
        input int         height
    );
        int a;
        a = int'(y) * width + int'(x);
        if (bank) begin
            a = a + width * height;
        end
        return ADDR_W'(a);
    endfunction

endpackage

// File: rtl/fb_write_fifo.sv
// ---------------------------------------------------------------------------
// fb_write_fifo -- synchronous write queue for pending pixel writes.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears the queue)
//   push, din  : enqueue din; accepted when not full, or when full and a pop
//                happens in the same cycle
//   pop, dout  : dequeue the head; dout is the current head (show-ahead)
//   full, empty: status flags decoded from the registered occupancy count
//
// DEPTH must be a power of two (>= 2) so the pointers wrap for free.
// ---------------------------------------------------------------------------
module fb_write_fifo
    import fb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  wr_entry_t din,
    input  logic      pop,
    output wr_entry_t dout,
    output logic      full,
    output logic      empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    wr_entry_t       mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic            do_push;
    logic            do_pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // A pop frees a slot in the same cycle, so a full queue may push and pop
    // together and keep its count.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/fb_arbiter.sv
// ---------------------------------------------------------------------------
// fb_arbiter -- single-port framebuffer RAM arbiter with double buffering.
//
// The display read path owns the RAM whenever it asks for an in-range pixel;
// game-logic writes are queued and drained into the back bank in cycles the
// display leaves free. A swap request is held until vertical blanking
// (counterV == VBLANK_LINE, counterH == 0) with the queue fully drained, then
// the front bank flips and swap_ack pulses for one cycle.
//
// Ports:
//   clk_in, reset_n       : pixel clock, asynchronous active-low reset
//   counterH, counterV    : free-running VGA timing counters
//   disp_req/x/y          : display read request and pixel coordinate
//   disp_rgb, disp_valid  : RGB332 read data, valid one cycle after disp_req
//   wr_valid/ready/x/y/rgb: game-logic pixel write channel
//   swap_req, swap_ack    : buffer swap request / one-cycle acknowledge
//   front_bank            : bank currently scanned out by the display
//   ram_addr/we/wdata     : single-port synchronous RAM command
//   ram_rdata             : RAM read data, one cycle after the address
//   swap_state            : swap FSM state (SWAP_IDLE/PEND/ACK encoding)
//
// Write channel handshake: a write transfers in every cycle where wr_valid
// and wr_ready are both high at the clock edge. The producer holds wr_x,
// wr_y and wr_rgb stable while wr_valid is high and wr_ready is low.
// wr_ready depends only on registered state (queue count and swap state),
// never on wr_valid. Out-of-range writes still complete the handshake but
// are discarded.
// ---------------------------------------------------------------------------
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int FB_W       = FB_W_DEFAULT,
    parameter int FB_H       = FB_H_DEFAULT
) (
    input  logic        clk_in,
    input  logic        reset_n,
    input  logic [9:0]  counterH,
    input  logic [9:0]  counterV,
    input  logic        disp_req,
    input  logic [8:0]  disp_x,
    input  logic [7:0]  disp_y,
    output logic [7:0]  disp_rgb,
    output logic        disp_valid,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [8:0]  wr_x,
    input  logic [7:0]  wr_y,
    input  logic [7:0]  wr_rgb,
    input  logic        swap_req,
    output logic        swap_ack,
    output logic        front_bank,
    output logic [17:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic [1:0]  swap_state
);

    swap_state_t state_q;
    swap_state_t state_d;
    logic        swap_go;
    logic        swap_point;

    logic        disp_in_range;
    logic        disp_hit;
    logic        rd_hit_q;

    logic        wr_in_range;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    wr_entry_t   fifo_din;
    wr_entry_t   fifo_head;

    // -----------------------------------------------------------------------
    // Range decode
    // -----------------------------------------------------------------------
    assign disp_in_range = ({1'b0, disp_x} < 10'(FB_W)) && ({1'b0, disp_y} < 9'(FB_H));
    assign wr_in_range   = ({1'b0, wr_x}   < 10'(FB_W)) && ({1'b0, wr_y}   < 9'(FB_H));

    // Gated with reset_n so the RAM command stays quiet while reset is held,
    // even if the display keeps requesting.
    assign disp_hit = reset_n && disp_req && disp_in_range;

    // -----------------------------------------------------------------------
    // Write queue
    // -----------------------------------------------------------------------
    // The back buffer is frozen from the swap request until the swap commits.
    assign wr_ready  = !fifo_full && (state_q == SWAP_IDLE);
    assign fifo_push = wr_valid && wr_ready && wr_in_range;
    assign fifo_pop  = !fifo_empty && !disp_hit;

    assign fifo_din.x   = wr_x;
    assign fifo_din.y   = wr_y;
    assign fifo_din.rgb = wr_rgb;

    fb_write_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_write_fifo (
        .clk   (clk_in),
        .rst_n (reset_n),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // -----------------------------------------------------------------------
    // RAM command mux: display read wins, otherwise drain one queued write.
    // -----------------------------------------------------------------------
    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (disp_hit) begin
            ram_addr = pixel_addr(front_bank, disp_x, disp_y, FB_W, FB_H);
        end else if (fifo_pop) begin
            ram_addr  = pixel_addr(~front_bank, fifo_head.x, fifo_head.y, FB_W, FB_H);
            ram_we    = 1'b1;
            ram_wdata = fifo_head.rgb;
        end
    end

    // -----------------------------------------------------------------------
    // Display return path: valid follows every request by one cycle; an
    // out-of-range request never touched the RAM and returns black.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            disp_valid <= 1'b0;
            rd_hit_q   <= 1'b0;
        end else begin
            disp_valid <= disp_req;
            rd_hit_q   <= disp_hit;
        end
    end

    assign disp_rgb = rd_hit_q ? ram_rdata : 8'h00;

    // -----------------------------------------------------------------------
    // Swap FSM
    // -----------------------------------------------------------------------
    assign swap_point = (counterV == VBLANK_LINE) && (counterH == 10'd0);

    always_comb begin
        state_d = state_q;
        swap_go = 1'b0;
        case (state_q)
            SWAP_IDLE: begin
                if (swap_req) begin
                    state_d = SWAP_PEND;
                end
            end
            SWAP_PEND: begin
                // Commit only with every queued pixel already in the RAM;
                // otherwise wait for the next frame's swap point.
                if (swap_point && fifo_empty && !ram_we) begin
                    state_d = SWAP_ACK;
                    swap_go = 1'b1;
                end
            end
            SWAP_ACK: begin
                state_d = SWAP_IDLE;
            end
            default: begin
                state_d = SWAP_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= SWAP_IDLE;
            front_bank <= 1'b0;
        end else begin
            state_q <= state_d;
            if (swap_go) begin
                front_bank <= ~front_bank;
            end
        end
    end

    assign swap_ack   = (state_q == SWAP_ACK);
    assign swap_state = state_q;

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, write-queue entries (power of 2, >=2).
REQ-002 SHALL have parameter FB_W, default 320, framebuffer width in pixels.
REQ-003 SHALL have parameter FB_H, default 240, framebuffer height in lines.
REQ-004 SHALL have port clk_in  input  1  pixel clock; the only clock.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports counterH/counterV  input  10 each  free-running VGA timing counters.
REQ-007 SHALL have ports disp_req  input  1, disp_x  input  9, disp_y  input  8  display read request and coordinate.
REQ-008 SHALL have ports disp_rgb  output  8, disp_valid  output  1  RGB332 read data and qualifier.
REQ-009 SHALL have ports wr_valid  input  1, wr_ready  output  1, wr_x  input  9, wr_y  input  8, wr_rgb  input  8  game-logic write channel.
REQ-010 SHALL have ports swap_req  input  1, swap_ack  output  1, front_bank  output  1  double-buffer swap handshake and current display bank.
REQ-011 SHALL have ports ram_addr  output  18, ram_we  output  1, ram_wdata  output  8, ram_rdata  input  8  single-port synchronous RAM, 1-cycle read latency.

Function
REQ-012 SHALL compute address = bank*FB_W*FB_H + y*FB_W + x; display reads use front_bank, writes use ~front_bank.
REQ-013 SHALL give display reads absolute priority: disp_req high in cycle N drives a RAM read in cycle N.
REQ-014 SHALL assert disp_valid in cycle N+1 with disp_rgb = ram_rdata, exactly one cycle after each disp_req.
REQ-015 SHALL, for disp_x>=FB_W or disp_y>=FB_H, issue no RAM access and return disp_rgb=0 with disp_valid at N+1.
REQ-016 SHALL accept a write (wr_valid & wr_ready) into the FIFO; wr_ready = queue not full, combinationally from registered count.
REQ-017 SHALL pop the FIFO head to the RAM (ram_we=1) only in a cycle with no in-range disp_req.
REQ-018 SHALL allow simultaneous push and pop in one cycle, including when full (count unchanged; wr_ready stays low when full at cycle start).
REQ-019 SHALL drop out-of-range writes at push time (handshake completes; nothing queued).
REQ-020 SHALL implement swap FSM states IDLE, PEND, ACK: IDLE->PEND on swap_req; PEND->ACK at counterV==515 && counterH==0 if FIFO empty and no write pending to the RAM that cycle, else stay PEND; ACK->IDLE after one cycle.
REQ-021 SHALL toggle front_bank on PEND->ACK and pulse swap_ack for exactly the ACK cycle.
REQ-022 SHALL deassert wr_ready while in PEND or ACK so the back buffer is frozen until the swap.
REQ-023 SHALL ignore swap_req in PEND and ACK (no queuing of a second swap).

Reset
REQ-024 SHALL on reset_n low asynchronously clear: FIFO empty, swap state IDLE, front_bank=0, swap_ack=0, disp_valid=0, disp_rgb=0, ram_we=0, ram_addr=0, ram_wdata=0.
REQ-025 SHALL discard queued writes and any pending swap on reset mid-operation; first cycle after release behaves as idle.

Structure
REQ-026 SHALL take FB_W/FB_H defaults, FRAME_WORDS (76800), VBLANK_LINE (515) and swap-state enum from shared package fb_pkg.
REQ-027 SHALL place the write queue in sub-module fb_write_fifo (synchronous, count-based full/empty).

Verification
REQ-028 SHALL cover: disp_req every cycle with wr_valid high -> no ram_we ever, wr_ready low after 4 accepts.
REQ-029 SHALL cover: disp_req on even cycles only, 8 writes queued -> all 8 written on odd cycles in push order, to bank 1.
REQ-030 SHALL cover: disp read (10,5) after write rgb=8'hE3 then swap -> disp_rgb=8'hE3 at address 76800+1610 read path.
REQ-031 SHALL cover: swap_req with 2 writes queued and continuous disp_req through line 515 -> no ack that frame; ack next frame after drain.
REQ-032 SHALL cover: disp_x=320 and wr_y=240 -> disp_rgb=0 with disp_valid, write dropped, no RAM access.
REQ-033 SHALL cover: reset_n low in PEND with full FIFO -> front_bank=0, wr_ready=1 one cycle after release, no swap_ack.
